// File: rtl/unload_fifo_pkg.sv
// Shared definitions for the FIFO-to-RAM unloader: FSM encodings, bus widths
// and the default pad byte used to complete an odd-length transfer.
package unload_fifo_pkg;

    localparam int RAM_DW = 16;
    localparam int RAM_AW = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h00;

    typedef logic [RAM_AW-1:0] ram_addr_t;
    typedef logic [RAM_DW-1:0] ram_word_t;

endpackage

// File: rtl/unload_fifo_to_ram_packer.sv
// Byte-pair packer: holds the high byte and the byte-select flag, and
// presents a big-endian 16-bit word with a one-cycle word_ready strobe.
module byte_pair_packer
    import unload_fifo_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic        flush,
    input  logic [7:0]  data_in,
    output logic        byte_sel,
    output ram_word_t   word,
    output logic        word_ready
);

    logic [7:0] hi_q, hi_d;
    logic       byte_sel_q, byte_sel_d;

    always_comb begin
        hi_d       = hi_q;
        byte_sel_d = byte_sel_q;
        if (clear) begin
            hi_d       = 8'h00;
            byte_sel_d = 1'b0;
        end else if (flush) begin
            byte_sel_d = 1'b0;
        end else if (load) begin
            if (!byte_sel_q) begin
                hi_d       = data_in;
                byte_sel_d = 1'b1;
            end else begin
                byte_sel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q       <= 8'h00;
            byte_sel_q <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            byte_sel_q <= byte_sel_d;
        end
    end

    // A flush completes an odd-length transfer with the pad byte as low byte.
    assign word       = flush ? {hi_q, PAD_BYTE} : {hi_q, data_in};
    assign word_ready = flush | (load & byte_sel_q);
    assign byte_sel   = byte_sel_q;

endmodule

// File: rtl/unload_fifo_to_ram.sv
// Drains n_reads bytes from a one-cycle-latency FIFO, packs them big-endian
// into 16-bit words and writes them to consecutive RAM addresses.
module unload_fifo_to_ram
    import unload_fifo_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter logic [7:0] PAD_BYTE  = PAD_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        n_reads,
    output logic              done,
    output logic              error,
    input  logic [7:0]        fifo_data_in,
    output logic              fifo_rd_en,
    input  logic              fifo_empty,
    input  logic              fifo_valid,
    input  logic              fifo_underflow,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_data,
    output logic              ram_we
);

    logic [2:0] state_q, state_d;
    logic [7:0] remaining_q, remaining_d;
    ram_addr_t  addr_q, addr_d;
    ram_word_t  data_q, data_d;
    logic       error_q, error_d;

    logic       pk_clear, pk_load, pk_flush;
    logic       pk_byte_sel, pk_word_ready;
    ram_word_t  pk_word;

    byte_pair_packer #(
        .PAD_BYTE (PAD_BYTE)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .load       (pk_load),
        .flush      (pk_flush),
        .data_in    (fifo_data_in),
        .byte_sel   (pk_byte_sel),
        .word       (pk_word),
        .word_ready (pk_word_ready)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        error_d     = error_q;
        pk_clear    = 1'b0;
        pk_load     = 1'b0;
        pk_flush    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = n_reads;
                    addr_d      = BASE_ADDR;
                    error_d     = 1'b0;
                    pk_clear    = 1'b1;
                    state_d     = (n_reads == 8'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (remaining_q != 8'd0) begin
                    if (!fifo_empty) begin
                        state_d = S_WAIT;
                    end
                end else if (pk_byte_sel) begin
                    pk_flush = 1'b1;
                    state_d  = S_WRITE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                if (fifo_valid) begin
                    pk_load     = 1'b1;
                    remaining_d = (remaining_q != 8'd0) ? remaining_q - 8'd1 : 8'd0;
                    state_d     = pk_byte_sel ? S_WRITE : S_REQ;
                end else begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 8'd1;
                state_d = (remaining_q != 8'd0) ? S_REQ : S_DONE;
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Underflow aborts the transfer from any busy state; a half-built word is dropped.
        if (fifo_underflow && (state_q != S_IDLE)) begin
            state_d     = S_DONE;
            error_d     = 1'b1;
            remaining_d = remaining_q;
            addr_d      = addr_q;
            pk_load     = 1'b0;
            pk_flush    = 1'b0;
        end
    end

    always_comb begin
        data_d = data_q;
        if (pk_word_ready) begin
            data_d = pk_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= 8'd0;
            addr_q      <= BASE_ADDR;
            data_q      <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            error_q     <= error_d;
        end
    end

    assign fifo_rd_en = (state_q == S_REQ) & ~fifo_empty & (remaining_q != 8'd0);
    assign ram_we     = (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign error      = error_q;
    assign ram_addr   = addr_q;
    assign ram_data   = data_q;

endmodule

// File: tb/tb_unload_fifo_to_ram.sv
// Bench for unload_fifo_to_ram: a FIFO model feeds two instances (base 0x10
// and base 0xFF); RAM writes are checked against a packed-word scoreboard.
module tb_unload_fifo_to_ram;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] n_reads = 8'd0;
    logic [7:0] fifo_data_in = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       fifo_valid = 1'b0;
    logic       fifo_underflow = 1'b0;

    logic        done, error, fifo_rd_en, ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_data;
    logic        w_done, w_error, w_rd_en, w_we;
    logic [7:0]  w_addr;
    logic [15:0] w_data;

    logic [7:0]  fifo_q[$];
    logic [7:0]  stim[$];
    logic [23:0] exp_a[$];
    logic [23:0] exp_b[$];
    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;

    localparam logic [7:0] BASE_A = 8'h10;
    localparam logic [7:0] BASE_B = 8'hFF;
    localparam logic [7:0] PAD    = 8'h00;

    unload_fifo_to_ram #(.BASE_ADDR(BASE_A)) u_dut (
        .clk(clk), .reset(reset), .start(start), .n_reads(n_reads),
        .done(done), .error(error), .fifo_data_in(fifo_data_in),
        .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
        .fifo_underflow(fifo_underflow), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_we(ram_we)
    );

    unload_fifo_to_ram #(.BASE_ADDR(BASE_B)) u_wrap (
        .clk(clk), .reset(reset), .start(start), .n_reads(n_reads),
        .done(w_done), .error(w_error), .fifo_data_in(fifo_data_in),
        .fifo_rd_en(w_rd_en), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
        .fifo_underflow(fifo_underflow), .ram_addr(w_addr), .ram_data(w_data),
        .ram_we(w_we)
    );

    always #5 clk = ~clk;

    // Standard FIFO: data appears with fifo_valid one cycle after a read strobe.
    always @(posedge clk) begin
        fifo_valid <= 1'b0;
        if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_data_in <= fifo_q.pop_front();
            fifo_valid   <= 1'b1;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (fifo_rd_en) begin
                rd_cnt++;
                check("rd_en_while_empty", {31'd0, fifo_empty}, 32'd0);
            end
            if (ram_we) begin
                if (exp_a.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write_a: got %h_%h expected no write", ram_addr, ram_data);
                end else begin
                    check("ram_write_a", {8'd0, ram_addr, ram_data}, {8'd0, exp_a.pop_front()});
                end
            end
            if (w_we) begin
                if (exp_b.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write_b: got %h_%h expected no write", w_addr, w_data);
                end else begin
                    check("ram_write_b", {8'd0, w_addr, w_data}, {8'd0, exp_b.pop_front()});
                end
            end
        end
    end

    // Expected words: pairs of stimulus bytes, high byte first, padded when odd.
    task automatic model_expect();
        int n = stim.size();
        int words = (n + 1) / 2;
        for (int i = 0; i < words; i++) begin
            logic [7:0] hi = stim[2*i];
            logic [7:0] lo = (2*i + 1 < n) ? stim[2*i+1] : PAD;
            logic [7:0] off = i[7:0];
            exp_a.push_back({BASE_A + off, hi, lo});
            exp_b.push_back({BASE_B + off, hi, lo});
        end
    endtask

    function automatic int model_cycles(input int n);
        int words = (n + 1) / 2;
        if (n == 0) return 1;
        return 2*n + words + (n % 2) + 1;
    endfunction

    task automatic fifo_load(input bit fill);
        fifo_q.delete();
        if (fill) foreach (stim[i]) fifo_q.push_back(stim[i]);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_xfer(input string nm, input int push_delay, input int hold, input int exp_cyc);
        int n = stim.size();
        int words = (n + 1) / 2;
        int cyc = 0;
        bit got = 0;
        int rd_base;
        fifo_load(push_delay == 0);
        rd_base = rd_cnt;
        n_reads = n[7:0];
        start = 1'b1;
        while (!got && cyc < 500) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (push_delay > 0 && cyc < push_delay)
                check({nm, "_stall_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
            if (push_delay > 0 && cyc == push_delay)
                foreach (stim[i]) fifo_q.push_back(stim[i]);
            if (done) got = 1;
            if (hold == 0) start = 1'b0;
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got no done expected done within 500 cycles", nm);
        end
        if (exp_cyc >= 0) check({nm, "_latency"}, cyc, exp_cyc);
        check({nm, "_error"}, {31'd0, error}, 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({nm, "_held_done"}, {31'd0, done}, 32'd1);
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({nm, "_done_drop"}, {31'd0, done}, 32'd0);
        check({nm, "_reads"}, rd_cnt - rd_base, n);
        check({nm, "_writes_left"}, exp_a.size() + exp_b.size(), 0);
        check({nm, "_final_addr_a"}, {24'd0, ram_addr}, {24'd0, BASE_A + words[7:0]});
        check({nm, "_final_addr_b"}, {24'd0, w_addr}, {24'd0, BASE_B + words[7:0]});
        $display("[TB] xfer %s n=%0d cycles=%0d reads=%0d", nm, n, cyc, rd_cnt - rd_base);
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_done"},  {31'd0, done}, 32'd0);
        check({nm, "_error"}, {31'd0, error}, 32'd0);
        check({nm, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
        check({nm, "_we"},    {31'd0, ram_we}, 32'd0);
        check({nm, "_addr"},  {24'd0, ram_addr}, {24'd0, BASE_A});
        check({nm, "_data"},  {16'd0, ram_data}, 32'd0);
        check({nm, "_addr_b"}, {24'd0, w_addr}, {24'd0, BASE_B});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        stim = {8'h11, 8'h22, 8'h33, 8'h44};
        model_expect();
        check("model_t1_w0", {8'd0, exp_a[0]}, 32'h00101122);
        check("model_t1_wrap_w1", {8'd0, exp_b[1]}, 32'h00003344);
        do_xfer("four_bytes", 0, 0, 11);

        stim = {8'hAA, 8'hBB, 8'hCC};
        model_expect();
        check("model_t2_w1", {8'd0, exp_a[1]}, 32'h0011CC00);
        do_xfer("odd_three", 0, 0, 10);

        stim.delete();
        model_expect();
        do_xfer("zero", 0, 0, 1);

        stim = {8'h5A, 8'hC3};
        model_expect();
        do_xfer("stall_empty", 20, 0, -1);

        // Underflow during the wait for the first byte: abort, no write.
        stim = {8'h55, 8'h66};
        fifo_load(1'b1);
        n_reads = 8'd2;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("uf_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        fifo_underflow = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fifo_underflow = 1'b0;
        check("uf_done", {31'd0, done}, 32'd1);
        check("uf_error", {31'd0, error}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("uf_error_sticky", {31'd0, error}, 32'd1);
        check("uf_no_write", {24'd0, ram_addr}, {24'd0, BASE_A});
        $display("[TB] xfer underflow error=%0d done=%0d", error, done);

        stim = {8'h01, 8'h02, 8'h03, 8'h04};
        model_expect();
        do_xfer("after_uf", 0, 0, model_cycles(4));

        stim = {8'h5A, 8'hA5};
        model_expect();
        do_xfer("held_start", 0, 5, model_cycles(2));

        // Reset lands after the first word was written, mid second word.
        stim = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        exp_a.push_back({BASE_A, 8'hA1, 8'hB2});
        exp_b.push_back({BASE_B, 8'hA1, 8'hB2});
        fifo_load(1'b1);
        n_reads = 8'd4;
        start = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("mid_reset");
        reset = 1'b0;
        check("mid_reset_writes_left", exp_a.size() + exp_b.size(), 0);
        $display("[TB] xfer mid_reset addr=%h data=%h", ram_addr, ram_data);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/unload_fifo_to_ram.md
Name: unload_fifo_to_ram

Overview:
Reader-side counterpart of the ROM-to-FIFO loader in the sensor module. On `start`, drains exactly `n_reads` bytes from a standard (non-FWFT) byte FIFO with one-cycle read latency. Packs byte pairs big-endian into 16-bit words and writes them to a 16-bit-wide RAM at consecutive addresses from `BASE_ADDR`. Signals `done` on completion and `error` on a FIFO underflow or a missing read response.

Parameters:
- BASE_ADDR, 8'h00, first RAM word address written per transfer.
- PAD_BYTE, 8'h00, low byte used when `n_reads` is odd.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin transfer; sampled only in S_IDLE.
- n_reads  in  8  byte count; latched on accepted start.
- done  out  1  high while in S_DONE.
- error  out  1  sticky per transfer; cleared on next accepted start.
- fifo_data_in  in  8  FIFO read data; valid with fifo_valid.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_empty  in  1  FIFO empty flag.
- fifo_valid  in  1  read data valid, one cycle after fifo_rd_en.
- fifo_underflow  in  1  FIFO read-while-empty indication.
- ram_addr  out  8  RAM word address.
- ram_data  out  16  RAM write data.
- ram_we  out  1  RAM write enable, one-cycle pulse per word.

Behaviour:
- Reset values: done=0, error=0, fifo_rd_en=0, ram_we=0, ram_addr=BASE_ADDR, ram_data=16'h0000, state=S_IDLE, byte_sel=0, remaining=0.
- Reset mid-transfer aborts immediately. No RAM write, partial word discarded.
- States:
  - S_IDLE, S_REQ, S_WAIT, S_WRITE, S_DONE.
- S_IDLE: on start, latch remaining=n_reads, ram_addr=BASE_ADDR, byte_sel=0, error=0.
  - If n_reads==0, go to S_DONE (no reads, no writes).
  - Otherwise go to S_REQ.
- S_REQ:
  - If remaining!=0 and !fifo_empty: fifo_rd_en=1 this cycle, go to S_WAIT.
  - If remaining!=0 and fifo_empty: stall in S_REQ with fifo_rd_en=0. No timeout.
  - If remaining==0 and byte_sel==1 (odd count): low byte=PAD_BYTE, go to S_WRITE.
  - If remaining==0 and byte_sel==0: go to S_DONE.
- fifo_rd_en is combinational: (state==S_REQ) & ~fifo_empty & (remaining!=0). It is never high in any other state.
- S_WAIT:
  - If fifo_valid and byte_sel==0: hi byte=fifo_data_in, byte_sel=1, remaining-=1, go to S_REQ.
  - If fifo_valid and byte_sel==1: ram_data={hi, fifo_data_in}, byte_sel=0, remaining-=1, go to S_WRITE.
  - If fifo_valid is low: set error=1, go to S_DONE.
- fifo_underflow high in any non-idle state: error=1, go to S_DONE next cycle. This has priority over all other transitions.
- S_WRITE: ram_we=1 for exactly this cycle, with ram_addr and ram_data stable.
  - On exit, ram_addr+=1, wrapping 8'hFF->8'h00.
  - Next state is S_REQ if remaining!=0, else S_DONE.
- S_DONE: done=1. Stay until start==0, then go to S_IDLE. A held start does not retrigger.
- start outside S_IDLE is ignored.
- Counts and throughput:
  - Words written = ceil(n_reads/2); final address = BASE_ADDR + words - 1 (mod 256).
  - With a non-empty FIFO, throughput is 5 cycles per word (REQ, WAIT, REQ, WAIT, WRITE).
- All arithmetic is 8-bit unsigned; remaining never decrements below 0.

Decomposition:
- Shared package unload_fifo_pkg holds:
  - state encodings S_IDLE..S_DONE (3-bit);
  - default PAD_BYTE;
  - RAM data width 16 and address width 8.
- One natural sub-module: byte_pair_packer.
  - Holds the hi-byte register and byte_sel.
  - Outputs the 16-bit word and a word_ready strobe.
  - Flush input applies PAD_BYTE.
- The FSM, counters and address register stay in the top.

Test Plan:
- FIFO preloaded 0x11,0x22,0x33,0x44; n_reads=4, BASE_ADDR=0x10 -> writes RAM[0x10]=0x1122 then RAM[0x11]=0x3344; exactly 4 rd_en pulses; done after 11 cycles from start; error=0.
- FIFO 0xAA,0xBB,0xCC; n_reads=3 -> RAM[0x10]=0xAABB, RAM[0x11]=0xCC00; 3 reads, 2 writes; done=1.
- n_reads=0 -> done on the cycle after start; no rd_en, no ram_we; ram_addr=BASE_ADDR.
- FIFO empty for 20 cycles, then 2 bytes pushed; n_reads=2 -> fifo_rd_en stays low while empty, then one write; no error.
- Underflow: fifo_underflow forced high during S_WAIT -> error=1, done=1 next cycle, no RAM write of the partial word; the next start clears error.
- BASE_ADDR=0xFF, n_reads=4 -> writes at 0xFF then 0x00 (wrap).
- Reset asserted mid-transfer -> all outputs at reset values next cycle.
- Start held high through S_DONE -> no retrigger until start drops.
